gshare_predictor_pipelined: RTL and testbench

Parametrised gshare direction predictor for the OoO front end. It replaces the single-counter predictor.
- Table: 2^IDX_BITS saturating counters, indexed by PC XOR speculative global history.
- Fetch gets a prediction plus an index/history snapshot for each branch.
- Branch resolution (ROB/branch unit) trains the table through the snapshot and repairs history on mispredict.
- After reset, a sweep FSM initialises the table one entry per cycle, so the table can map to RAM-style storage.

---
 rtl/gshare_predictor_pipelined.sv | 111 +++++++++++
 tb/tb_gshare_predictor_pipelined.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor_pipelined.sv
// rtl/gshare_predictor_pipelined.sv - gshare direction predictor with init sweep and history repair
module gshare_predictor_pipelined #(
  parameter int IDX_BITS  = 10,
  parameter int HIST_BITS = 10,
  parameter int CTR_BITS  = 2,
  parameter int CTR_INIT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 req_valid,
  input  logic [31:0]          req_pc,
  output logic                 pred_taken,
  output logic [IDX_BITS-1:0]  pred_idx,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 upd_valid,
  input  logic [IDX_BITS-1:0]  upd_idx,
  input  logic [HIST_BITS-1:0] upd_ghr,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  output logic [HIST_BITS-1:0] spec_ghr
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [IDX_BITS-1:0]  sweep_q, sweep_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [CTR_BITS-1:0]  table_q [ENTRIES];

  logic                 sweep_we;
  logic                 tbl_we;
  logic [IDX_BITS-1:0]  wr_idx;
  logic [CTR_BITS-1:0]  wr_data;
  logic [CTR_BITS-1:0]  upd_ctr;
  logic [CTR_BITS-1:0]  upd_next;
  logic                 unused_bits;

  assign unused_bits = ^{req_pc, upd_ghr};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && sweep_q == {IDX_BITS{1'b1}}) state_d = S_RUN;
  end

  always_comb begin
    ready    = 1'b0;
    sweep_we = 1'b0;
    case (state_q)
      S_INIT:  sweep_we = 1'b1;
      S_RUN:   ready    = 1'b1;
      default: ready    = 1'b0;
    endcase
  end

  assign sweep_d = sweep_we ? sweep_q + IDX_BITS'(1) : sweep_q;

  always_ff @(posedge clk) begin
    if (rst) sweep_q <= '0;
    else     sweep_q <= sweep_d;
  end

  // Two combinational read ports: prediction and the update's read-modify-write.
  assign pred_idx   = req_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign pred_taken = ready & req_valid & table_q[pred_idx][CTR_BITS-1];
  assign pred_ghr   = ghr_q;
  assign spec_ghr   = ghr_q;

  assign upd_ctr = table_q[upd_idx];

  always_comb begin
    upd_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_next = upd_ctr + CTR_BITS'(1);
    end else begin
      if (upd_ctr != '0) upd_next = upd_ctr - CTR_BITS'(1);
    end
  end

  // Sweep owns the write port in INIT, training owns it in RUN.
  assign tbl_we  = !rst && (sweep_we || (ready && upd_valid));
  assign wr_idx  = sweep_we ? sweep_q : upd_idx;
  assign wr_data = sweep_we ? CTR_BITS'(CTR_INIT) : upd_next;

  always_ff @(posedge clk) begin
    if (tbl_we) table_q[wr_idx] <= wr_data;
  end

  // Repair wins over the wrong-path request's shift.
  always_comb begin
    ghr_d = ghr_q;
    if (ready) begin
      if (upd_valid && upd_mispredict) ghr_d = HIST_BITS'({upd_ghr, upd_taken});
      else if (req_valid)              ghr_d = HIST_BITS'({ghr_q, pred_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

endmodule

// File: tb/tb_gshare_predictor_pipelined.sv
// tb/tb_gshare_predictor_pipelined.sv - directed self-checking bench for gshare_predictor_pipelined
module tb_gshare_predictor_pipelined;

  localparam int IDX_BITS  = 4;
  localparam int HIST_BITS = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ready;
  logic                 req_valid = 1'b0;
  logic [31:0]          req_pc = '0;
  logic                 pred_taken;
  logic [IDX_BITS-1:0]  pred_idx;
  logic [HIST_BITS-1:0] pred_ghr;
  logic                 upd_valid = 1'b0;
  logic [IDX_BITS-1:0]  upd_idx = '0;
  logic [HIST_BITS-1:0] upd_ghr = '0;
  logic                 upd_taken = 1'b0;
  logic                 upd_mispredict = 1'b0;
  logic [HIST_BITS-1:0] spec_ghr;

  int checks = 0;
  int failures = 0;

  gshare_predictor_pipelined #(
    .IDX_BITS(IDX_BITS), .HIST_BITS(HIST_BITS), .CTR_BITS(2), .CTR_INIT(1)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .req_valid(req_valid), .req_pc(req_pc),
    .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .spec_ghr(spec_ghr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_sweep();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("init_ready_low_%0d", i), {31'd0, ready}, 32'd0);
      step();
    end
    check("init_ready_high", {31'd0, ready}, 32'd1);
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic exp_taken);
    req_valid = 1'b1;
    req_pc    = pc;
    #1;
    check(tag, {31'd0, pred_taken}, {31'd0, exp_taken});
    req_valid = 1'b0;
  endtask

  task automatic train(input logic [3:0] idx, input logic taken);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = taken;
    step();
    upd_valid = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_ghr", {28'd0, spec_ghr}, 32'd0);
    // Requests and updates during INIT must be ignored.
    req_valid = 1'b1; req_pc = 32'h14;
    upd_valid = 1'b1; upd_idx = 4'd5; upd_taken = 1'b1; upd_mispredict = 1'b1; upd_ghr = 4'hF;
    #1;
    check("init_pred_gated", {31'd0, pred_taken}, 32'd0);
    step(); step(); step(); step(); step();
    req_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    check("init_ghr_untouched", {28'd0, spec_ghr}, 32'd0);

    // Mid-INIT reset restarts the full sweep.
    do_reset();
    wait_sweep();
    check("run_ghr_zero", {28'd0, spec_ghr}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      probe($sformatf("init_entry_%0d", i), i << 2, 1'b0);
    end

    // Saturation on idx 5 (ghr stays 0 without requests).
    train(4'd5, 1'b1); probe("sat_up_2", 32'h14, 1'b1);
    train(4'd5, 1'b1); probe("sat_up_3", 32'h14, 1'b1);
    train(4'd5, 1'b1); probe("sat_up_3b", 32'h14, 1'b1);
    train(4'd5, 1'b1); probe("sat_up_3c", 32'h14, 1'b1);
    train(4'd5, 1'b0); probe("sat_dn_2", 32'h14, 1'b1);
    train(4'd5, 1'b0); probe("sat_dn_1", 32'h14, 1'b0);
    train(4'd5, 1'b0); probe("sat_dn_0", 32'h14, 1'b0);
    train(4'd5, 1'b0); probe("sat_dn_0b", 32'h14, 1'b0);
    train(4'd5, 1'b1); probe("sat_back_1", 32'h14, 1'b0);
    train(4'd5, 1'b1); probe("sat_back_2", 32'h14, 1'b1);
    check("ghr_after_training", {28'd0, spec_ghr}, 32'd0);

    // History shift: predictions 1,0,1 -> ghr 0101.
    req_valid = 1'b1; req_pc = 32'h14; #1;
    check("hist_p1", {31'd0, pred_taken}, 32'd1);
    step();
    check("hist_g1", {28'd0, spec_ghr}, 32'h1);
    req_pc = 32'h00; #1;
    check("hist_p2_idx", {28'd0, pred_idx}, 32'h1);
    check("hist_p2", {31'd0, pred_taken}, 32'd0);
    step();
    check("hist_g2", {28'd0, spec_ghr}, 32'h2);
    req_pc = 32'h1C; #1;
    check("hist_p3", {31'd0, pred_taken}, 32'd1);
    step();
    req_valid = 1'b0;
    check("hist_g3", {28'd0, spec_ghr}, 32'h5);
    req_pc = 32'h40; #1;
    check("hist_idx", {28'd0, pred_idx}, 32'h5);
    check("hist_pred_ghr", {28'd0, pred_ghr}, 32'h5);

    // Repair sets ghr to 0111, then repair beats a same-cycle request.
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_idx = 4'd15; upd_ghr = 4'b0011; upd_taken = 1'b1;
    step();
    check("repair_ghr", {28'd0, spec_ghr}, 32'h7);
    req_valid = 1'b1; req_pc = 32'h14;
    upd_idx = 4'd14; upd_ghr = 4'b0010; upd_taken = 1'b1;
    step();
    req_valid = 1'b0; upd_mispredict = 1'b0;
    check("repair_priority", {28'd0, spec_ghr}, 32'h5);
    upd_idx = 4'd14;
    step();
    upd_valid = 1'b0;
    check("update_no_mp_ghr", {28'd0, spec_ghr}, 32'h5);

    // Same-index collision at idx 9: predict sees pre-update counter.
    req_valid = 1'b1; req_pc = 32'h30;
    upd_valid = 1'b1; upd_idx = 4'd9; upd_taken = 1'b1; upd_mispredict = 1'b0;
    #1;
    check("coll_idx", {28'd0, pred_idx}, 32'h9);
    check("coll_pred_old", {31'd0, pred_taken}, 32'd0);
    step();
    req_valid = 1'b0; upd_valid = 1'b0;
    check("coll_ghr", {28'd0, spec_ghr}, 32'hA);
    probe("coll_pred_new", 32'h0C, 1'b1);

    // Reset mid-run: idx 3 trained to 3 returns to CTR_INIT.
    train(4'd3, 1'b1);
    train(4'd3, 1'b1);
    probe("mid_idx3_trained", 32'h24, 1'b1);
    do_reset();
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_ghr", {28'd0, spec_ghr}, 32'd0);
    wait_sweep();
    probe("mid_idx3_reinit", 32'h0C, 1'b0);
    probe("mid_idx5_reinit", 32'h14, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
